// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - valid-tagged register pipeline with stall and flush
// Optional feature macro: PIPE_REG_BUBBLE_COLLAPSE_EN (stalled entries close up bubbles)
module pipe_reg #(
  parameter int                WIDTH     = 32,
  parameter int                STAGES    = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  output logic [$clog2(STAGES+1)-1:0]  count
);

  localparam int CW = $clog2(STAGES + 1);

  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;

`ifdef PIPE_REG_BUBBLE_COLLAPSE_EN
  // A stage may load when the stall is lifted or any stage at or after it is empty.
  always_comb begin
    logic open;
    adv  = '0;
    open = en;
    for (int k = STAGES - 1; k >= 0; k--) begin
      open   = open | ~v[k];
      adv[k] = open;
    end
  end
`else
  always_comb begin
    adv = {STAGES{en}};
  end
`endif

  assign in_ready = adv[0];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < STAGES; k++) begin
        d[k] <= RESET_VAL;
      end
      v <= '0;
    end else begin
      // Data moves with adv regardless of validity; flush only touches valid bits.
      if (adv[0]) begin
        d[0] <= in_data;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          d[k] <= d[k-1];
        end
      end
      if (flush) begin
        v <= '0;
      end else begin
        if (adv[0]) begin
          v[0] <= in_valid;
        end
        for (int k = 1; k < STAGES; k++) begin
          if (adv[k]) begin
            v[k] <= v[k-1];
          end
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int k = 0; k < STAGES; k++) begin
      count = count + CW'(v[k]);
    end
  end

  assign out_data  = d[STAGES-1];
  assign out_valid = v[STAGES-1];

endmodule

// File: tb/tb_pipe_reg.sv
// tb/tb_pipe_reg.sv - scoreboard bench for pipe_reg at depths 1, 2 and 3
module tb_pipe_reg;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  // depth 2, 32 bits
  logic        en2 = 1'b0, flush2 = 1'b0, in_valid2 = 1'b0, in_ready2, out_valid2;
  logic [31:0] in_data2 = '0, out_data2;
  logic [1:0]  count2;
  // depth 1, 8 bits
  logic        en1 = 1'b0, flush1 = 1'b0, in_valid1 = 1'b0, in_ready1, out_valid1;
  logic [7:0]  in_data1 = '0, out_data1;
  logic        count1;
  // depth 3, 8 bits
  logic        en3 = 1'b0, flush3 = 1'b0, in_valid3 = 1'b0, in_ready3, out_valid3;
  logic [7:0]  in_data3 = '0, out_data3;
  logic [1:0]  count3;

  pipe_reg #(.WIDTH(32), .STAGES(2), .RESET_VAL(32'hDEADBEEF)) u2 (
    .clk(clk), .clr(clr), .en(en2), .flush(flush2), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2), .count(count2));
  pipe_reg #(.WIDTH(8), .STAGES(1), .RESET_VAL(8'h5A)) u1 (
    .clk(clk), .clr(clr), .en(en1), .flush(flush1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1), .count(count1));
  pipe_reg #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'h00)) u3 (
    .clk(clk), .clr(clr), .en(en3), .flush(flush3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3), .count(count3));

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] sb2[$];
  logic [7:0]  sb1[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr;
    clr = 1'b1;
    in_valid1 = 1'b0; in_valid2 = 1'b0; in_valid3 = 1'b0;
    flush1 = 1'b0; flush2 = 1'b0; flush3 = 1'b0;
    tick;
    clr = 1'b0;
  endtask

  task automatic test_reset;
    en2 = 1'b1; flush2 = 1'b1; in_valid2 = 1'b1; in_data2 = 32'h1234_5678;
    en1 = 1'b1; in_valid1 = 1'b1; in_data1 = 8'hFF;
    clr = 1'b1;
    tick;
    clr = 1'b0; flush2 = 1'b0; in_valid2 = 1'b0; in_valid1 = 1'b0;
    n_vec++; if (out_data2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reset_data2 got=%h exp=deadbeef", out_data2); end
    n_vec++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid2 got=%b exp=0", out_valid2); end
    n_vec++; if (count2 !== 2'd0) begin n_fail++; $display("FAIL reset_count2 got=%0d exp=0", count2); end
    n_vec++; if (out_data1 !== 8'h5A) begin n_fail++; $display("FAIL reset_data1 got=%h exp=5a", out_data1); end
    n_vec++; if (out_valid3 !== 1'b0 || count3 !== 2'd0) begin n_fail++; $display("FAIL reset_u3 got=%b/%0d exp=0/0", out_valid3, count3); end
    n_vec++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL ready_en1 got=%b exp=1", in_ready2); end
    en2 = 1'b0;
    #1;
`ifdef PIPE_REG_BUBBLE_COLLAPSE_EN
    n_vec++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL ready_empty_stall got=%b exp=1", in_ready2); end
`else
    n_vec++; if (in_ready2 !== 1'b0) begin n_fail++; $display("FAIL ready_empty_stall got=%b exp=0", in_ready2); end
`endif
  endtask

  task automatic test_latency;
    do_clr;
    en2 = 1'b1; in_valid2 = 1'b1; in_data2 = 32'h0000_00A5;
    tick;
    in_valid2 = 1'b0; in_data2 = 32'h0;
    n_vec++; if (out_valid2 !== 1'b0 || count2 !== 2'd1) begin n_fail++; $display("FAIL lat_edge1 got=%b/%0d exp=0/1", out_valid2, count2); end
    tick;
    n_vec++; if (out_data2 !== 32'hA5 || out_valid2 !== 1'b1) begin n_fail++; $display("FAIL lat_edge2 got=%h/%b exp=a5/1", out_data2, out_valid2); end
    n_vec++; if (count2 !== 2'd1) begin n_fail++; $display("FAIL lat_count got=%0d exp=1", count2); end
  endtask

  task automatic test_stream;
    int pv;
    int iv;
    logic [31:0] dat;
    logic [31:0] exp;
    do_clr;
    en2 = 1'b1; pv = 0;
    for (int i = 0; i < 24; i++) begin
      iv = int'($urandom_range(0, 1));
      dat = $urandom;
      in_valid2 = iv[0]; in_data2 = dat;
      if (iv != 0) sb2.push_back(dat);
      tick;
      n_vec++; if (int'(count2) !== iv + pv) begin n_fail++; $display("FAIL stream_count got=%0d exp=%0d", count2, iv + pv); end
      pv = iv;
      if (out_valid2) begin
        n_vec++;
        if (sb2.size() == 0) begin n_fail++; $display("FAIL stream_extra got=%h exp=none", out_data2); end
        else begin
          exp = sb2.pop_front();
          if (out_data2 !== exp) begin n_fail++; $display("FAIL stream_data got=%h exp=%h", out_data2, exp); end
        end
      end
    end
    in_valid2 = 1'b0;
    for (int i = 0; i < 4 && sb2.size() > 0; i++) begin
      tick;
      if (out_valid2) begin
        exp = sb2.pop_front();
        n_vec++; if (out_data2 !== exp) begin n_fail++; $display("FAIL drain_data got=%h exp=%h", out_data2, exp); end
      end
    end
    n_vec++; if (sb2.size() != 0) begin n_fail++; $display("FAIL drain_left got=%0d exp=0", sb2.size()); end
  endtask

  task automatic test_stall_flush;
    do_clr;
    en2 = 1'b1; in_valid2 = 1'b1;
    in_data2 = 32'h01; tick;
    in_data2 = 32'h02; tick;
    n_vec++; if (count2 !== 2'd2 || out_data2 !== 32'h01) begin n_fail++; $display("FAIL full got=%0d/%h exp=2/01", count2, out_data2); end
    en2 = 1'b0; in_data2 = 32'h11;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (in_ready2 !== 1'b0) begin n_fail++; $display("FAIL stall_ready got=%b exp=0", in_ready2); end
      tick;
      n_vec++; if (out_data2 !== 32'h01 || count2 !== 2'd2) begin n_fail++; $display("FAIL stall_hold got=%h/%0d exp=01/2", out_data2, count2); end
    end
    en2 = 1'b1; tick;
    n_vec++; if (out_data2 !== 32'h02 || out_valid2 !== 1'b1 || count2 !== 2'd2) begin n_fail++; $display("FAIL resume got=%h/%b/%0d exp=02/1/2", out_data2, out_valid2, count2); end
    flush2 = 1'b1; in_data2 = 32'h33; tick;
    flush2 = 1'b0; in_valid2 = 1'b0;
    n_vec++; if (out_valid2 !== 1'b0 || count2 !== 2'd0) begin n_fail++; $display("FAIL flush got=%b/%0d exp=0/0", out_valid2, count2); end
    n_vec++; if (out_data2 !== 32'h11) begin n_fail++; $display("FAIL flush_data got=%h exp=11", out_data2); end
    tick;
    n_vec++; if (out_data2 !== 32'h33 || out_valid2 !== 1'b0) begin n_fail++; $display("FAIL flush_tail got=%h/%b exp=33/0", out_data2, out_valid2); end
    in_valid2 = 1'b1; in_data2 = 32'h44; tick; tick;
    en2 = 1'b0; flush2 = 1'b1; clr = 1'b1; tick;
    clr = 1'b0; flush2 = 1'b0; in_valid2 = 1'b0;
    n_vec++; if (out_data2 !== 32'hDEADBEEF || out_valid2 !== 1'b0 || count2 !== 2'd0) begin n_fail++; $display("FAIL clr_mid got=%h/%b/%0d exp=deadbeef/0/0", out_data2, out_valid2, count2); end
  endtask

  task automatic test_single;
    logic [7:0] exp;
    do_clr;
    en1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid1 = (i % 2 == 0); in_data1 = 8'(8'h30 + i);
      if (in_valid1) sb1.push_back(in_data1);
      tick;
      n_vec++; if (out_valid1 !== (i % 2 == 0) || count1 !== (i % 2 == 0)) begin n_fail++; $display("FAIL single_toggle got=%b/%b exp=%b", out_valid1, count1, i % 2 == 0); end
      if (out_valid1) begin
        n_vec++;
        if (sb1.size() == 0) begin n_fail++; $display("FAIL single_extra got=%h exp=none", out_data1); end
        else begin
          exp = sb1.pop_front();
          if (out_data1 !== exp) begin n_fail++; $display("FAIL single_data got=%h exp=%h", out_data1, exp); end
        end
      end
    end
    n_vec++; if (sb1.size() != 0) begin n_fail++; $display("FAIL single_left got=%0d exp=0", sb1.size()); end
  endtask

  task automatic test_bubble;
    do_clr;
    en3 = 1'b1;
    in_valid3 = 1'b1; in_data3 = 8'h0A; tick;
    in_valid3 = 1'b0; in_data3 = 8'h0B; tick;
    in_valid3 = 1'b1; in_data3 = 8'h0C; tick;
    n_vec++; if (count3 !== 2'd2 || out_data3 !== 8'h0A || out_valid3 !== 1'b1) begin n_fail++; $display("FAIL bubble_setup got=%0d/%h exp=2/0a", count3, out_data3); end
    en3 = 1'b0; in_valid3 = 1'b1; in_data3 = 8'h07;
    #1;
`ifdef PIPE_REG_BUBBLE_COLLAPSE_EN
    n_vec++; if (in_ready3 !== 1'b1) begin n_fail++; $display("FAIL bubble_ready got=%b exp=1", in_ready3); end
    tick;
    in_valid3 = 1'b0;
    n_vec++; if (count3 !== 2'd3 || out_data3 !== 8'h0A) begin n_fail++; $display("FAIL bubble_close got=%0d/%h exp=3/0a", count3, out_data3); end
    en3 = 1'b1; tick;
    n_vec++; if (out_data3 !== 8'h0C || out_valid3 !== 1'b1 || count3 !== 2'd2) begin n_fail++; $display("FAIL bubble_next got=%h/%b/%0d exp=0c/1/2", out_data3, out_valid3, count3); end
    tick;
    n_vec++; if (out_data3 !== 8'h07 || out_valid3 !== 1'b1 || count3 !== 2'd1) begin n_fail++; $display("FAIL bubble_last got=%h/%b/%0d exp=07/1/1", out_data3, out_valid3, count3); end
`else
    n_vec++; if (in_ready3 !== 1'b0) begin n_fail++; $display("FAIL bubble_ready got=%b exp=0", in_ready3); end
    tick;
    in_valid3 = 1'b0;
    n_vec++; if (count3 !== 2'd2 || out_data3 !== 8'h0A) begin n_fail++; $display("FAIL bubble_hold got=%0d/%h exp=2/0a", count3, out_data3); end
    en3 = 1'b1; tick;
    n_vec++; if (out_data3 !== 8'h0B || out_valid3 !== 1'b0 || count3 !== 2'd1) begin n_fail++; $display("FAIL bubble_next got=%h/%b/%0d exp=0b/0/1", out_data3, out_valid3, count3); end
    tick;
    n_vec++; if (out_data3 !== 8'h0C || out_valid3 !== 1'b1 || count3 !== 2'd1) begin n_fail++; $display("FAIL bubble_last got=%h/%b/%0d exp=0c/1/1", out_data3, out_valid3, count3); end
`endif
  endtask

  initial begin
    #2;
    test_reset;
    test_latency;
    test_stream;
    test_stall_flush;
    test_single;
    test_bubble;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
